// File: rtl/bm3d_pkg.sv
// Shared defaults and helpers for the BM3D front end and block-matching core.
package bm3d_pkg;

    localparam int DEF_IMG_W = 640;
    localparam int DEF_BLK   = 4;
    localparam int DEF_DW    = 8;

    typedef logic [DEF_DW-1:0] pix_t;

    // (base + off) mod n, for a rotating bank pointer with n <= 7.
    function automatic logic [3:0] wrap_idx(input logic [3:0] base,
                                            input logic [3:0] off,
                                            input logic [3:0] n);
        logic [3:0] s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/bm3d_line_ram.sv
// One line buffer: single address, registered read, read-before-write on the same address.
module bm3d_line_ram
    import bm3d_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_W,
    parameter int DW    = DEF_DW,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_q;

    // No reset so the array and its output register map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rd_q <= mem[addr];
    end

    assign rdata = rd_q;

endmodule

// File: rtl/bm3d_win_buf.sv
// CMOS raster front end: tracks x/y, keeps the last BLK-1 lines in rotating line RAMs and
// emits one BLK-tall pixel column per accepted pixel, two clocks after the pixel arrives.
module bm3d_win_buf
    import bm3d_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int BLK   = DEF_BLK,
    parameter int DW    = DEF_DW,
    parameter int XW    = 10,
    parameter int YW    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic              cmos_de,
    input  logic [DW-1:0]     data_in,
    output logic              o_vsync,
    output logic              o_href,
    output logic              col_valid,
    output logic [BLK*DW-1:0] col_data,
    output logic [XW-1:0]     col_x,
    output logic [YW-1:0]     col_y,
    output logic              frame_sop,
    output logic              ovf
);

    localparam int NB = BLK - 1;
    localparam int SW = (NB > 1) ? $clog2(NB) : 1;
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic vs_rise, hr_fall, de_ok, acc;

    logic          vsync_prev_q, vsync_prev_d, href_prev_q, href_prev_d;
    logic          armed_q, armed_d, line_px_q, line_px_d;
    logic          ovf_q, ovf_d, sop_pend_q, sop_pend_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [SW-1:0] wr_sel_q, wr_sel_d;

    logic          acc1_q, acc1_d;
    logic [XW-1:0] x1_q, x1_d;
    logic [YW-1:0] y1_q, y1_d;
    logic [DW-1:0] pix1_q, pix1_d;
    logic [SW-1:0] sel1_q, sel1_d;

    logic              col_valid_q, col_valid_d, frame_sop_q, frame_sop_d;
    logic [BLK*DW-1:0] col_data_q, col_data_d;
    logic [XW-1:0]     col_x_q, col_x_d;
    logic [YW-1:0]     col_y_q, col_y_d;
    logic [1:0]        vs_dly_q, vs_dly_d, hr_dly_q, hr_dly_d;

    logic [DW-1:0]     rd_bank [NB];
    logic [BLK*DW-1:0] col_cat;

    // Bank wr_sel holds the oldest line, so it becomes the top row of the column.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bank
            bm3d_line_ram #(.DEPTH(IMG_W), .DW(DW), .AW(AW)) u_ram (
                .clk   (clk),
                .we    (acc && (wr_sel_q == SW'(gi))),
                .addr  (x_q[AW-1:0]),
                .wdata (data_in),
                .rdata (rd_bank[gi])
            );
            assign col_cat[(BLK-1-gi)*DW +: DW] =
                rd_bank[SW'(wrap_idx(4'(sel1_q), 4'(gi), 4'(NB)))];
        end
    endgenerate
    assign col_cat[DW-1:0] = pix1_q;

    always_comb begin
        vs_rise = vsync & ~vsync_prev_q;
        hr_fall = ~href & href_prev_q;
        de_ok   = armed_q & href & cmos_de;
        acc     = de_ok & (x_q < XW'(IMG_W));

        vsync_prev_d = vsync;
        href_prev_d  = href;
        armed_d      = armed_q | vs_rise;
        x_d          = x_q;
        y_d          = y_q;
        wr_sel_d     = wr_sel_q;
        line_px_d    = line_px_q;
        ovf_d        = ovf_q;
        sop_pend_d   = sop_pend_q;

        if (acc) begin
            x_d       = x_q + XW'(1);
            line_px_d = 1'b1;
        end
        if (de_ok && !acc) begin
            ovf_d = 1'b1;
        end
        if (hr_fall) begin
            x_d       = '0;
            line_px_d = 1'b0;
            if (line_px_q) begin
                y_d      = (y_q == {YW{1'b1}}) ? y_q : y_q + YW'(1);
                wr_sel_d = (wr_sel_q == SW'(NB-1)) ? '0 : wr_sel_q + SW'(1);
            end
        end

        acc1_d = acc;
        x1_d   = x_q;
        y1_d   = y_q;
        pix1_d = data_in;
        sel1_d = wr_sel_q;

        col_valid_d = acc1_q && (y1_q >= YW'(NB));
        col_x_d     = x1_q;
        col_y_d     = y1_q;
        col_data_d  = col_cat;
        frame_sop_d = col_valid_d && sop_pend_q;
        if (col_valid_d) begin
            sop_pend_d = 1'b0;
        end

        // A frame start overrides a coincident line end.
        if (vs_rise) begin
            x_d        = '0;
            y_d        = '0;
            wr_sel_d   = '0;
            line_px_d  = 1'b0;
            ovf_d      = 1'b0;
            sop_pend_d = 1'b1;
        end

        vs_dly_d = {vs_dly_q[0], vsync};
        hr_dly_d = {hr_dly_q[0], href};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
            armed_q      <= 1'b0;
            line_px_q    <= 1'b0;
            ovf_q        <= 1'b0;
            sop_pend_q   <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            wr_sel_q     <= '0;
            acc1_q       <= 1'b0;
            x1_q         <= '0;
            y1_q         <= '0;
            pix1_q       <= '0;
            sel1_q       <= '0;
            col_valid_q  <= 1'b0;
            frame_sop_q  <= 1'b0;
            col_data_q   <= '0;
            col_x_q      <= '0;
            col_y_q      <= '0;
            vs_dly_q     <= '0;
            hr_dly_q     <= '0;
        end else begin
            vsync_prev_q <= vsync_prev_d;
            href_prev_q  <= href_prev_d;
            armed_q      <= armed_d;
            line_px_q    <= line_px_d;
            ovf_q        <= ovf_d;
            sop_pend_q   <= sop_pend_d;
            x_q          <= x_d;
            y_q          <= y_d;
            wr_sel_q     <= wr_sel_d;
            acc1_q       <= acc1_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            pix1_q       <= pix1_d;
            sel1_q       <= sel1_d;
            col_valid_q  <= col_valid_d;
            frame_sop_q  <= frame_sop_d;
            col_data_q   <= col_data_d;
            col_x_q      <= col_x_d;
            col_y_q      <= col_y_d;
            vs_dly_q     <= vs_dly_d;
            hr_dly_q     <= hr_dly_d;
        end
    end

    assign o_vsync   = vs_dly_q[1];
    assign o_href    = hr_dly_q[1];
    assign col_valid = col_valid_q;
    assign col_data  = col_data_q;
    assign col_x     = col_x_q;
    assign col_y     = col_y_q;
    assign frame_sop = frame_sop_q;
    assign ovf       = ovf_q;

endmodule
